// File: rtl/mem_latency_responder_pkg.sv
// Shared definitions for the native valid/ready memory bus responder:
// MMIO/unmapped constants, read strobe encoding and FSM states.
package mem_latency_responder_pkg;

  localparam logic [31:0] OUT_ADDR_DEFAULT = 32'h1000_0000;
  localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam logic [3:0]  WSTRB_READ       = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_latency_responder_if.sv
// Native picorv32-style valid/ready memory bus.
interface mem_latency_responder_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_latency_responder_sram.sv
// DEPTH_WORDS x 32 single-port array: byte-enabled synchronous write,
// combinational read of the latched word address.
module mem_resp_sram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_latency_responder.sv
// Main-memory model behind the cache: wait-stated SRAM with an open-page
// fast path for sequential reads, plus one MMIO output register.
module mem_latency_responder
  import mem_latency_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned PAGE_LATENCY = 1,
  parameter int unsigned PAGE_WORDS   = 8,
  parameter logic [31:0] OUT_ADDR     = OUT_ADDR_DEFAULT,
  parameter logic [31:0] BAD_DATA     = BAD_DATA_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  mem_latency_responder_if.slave     bus,
  output logic [31:0]                out_byte,
  output logic                       out_byte_en
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(PAGE_WORDS);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        load;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [29:0] last_read;
  logic        last_valid;

  logic [29:0] in_word, req_word;
  logic        in_in_range, req_in_range;
  logic        seq_hit;
  logic [3:0]  wait_n;
  logic        resp, req_is_read, req_is_out;
  logic [3:0]  sram_we;
  logic [31:0] sram_rdata, rd_mux;

  assign in_word     = bus.mem_addr[31:2];
  assign req_word    = req_addr[31:2];
  assign in_in_range = {2'b00, in_word} < 32'(DEPTH_WORDS);
  assign req_in_range = {2'b00, req_word} < 32'(DEPTH_WORDS);

  // Fast path only for an in-range read continuing the last read inside its page
  assign seq_hit = last_valid && (bus.mem_wstrb == WSTRB_READ) && in_in_range
                   && (in_word == last_read + 30'd1)
                   && (in_word[29:PW] == last_read[29:PW]);
  assign wait_n  = seq_hit ? 4'(PAGE_LATENCY) : 4'(LATENCY);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          load      = 1'b1;
          cnt_nxt   = wait_n;
          state_nxt = (wait_n == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.mem_valid)  state_nxt = ST_IDLE;
        else if (cnt == 4'd1) state_nxt = ST_RESP;
        else                  cnt_nxt   = cnt - 4'd1;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign resp        = (state == ST_RESP);
  assign req_is_read = (req_wstrb == WSTRB_READ);
  assign req_is_out  = (req_addr == (OUT_ADDR & 32'hFFFF_FFFC));
  assign sram_we     = (resp && req_in_range && !req_is_out) ? req_wstrb : '0;

  mem_resp_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (req_word[AW-1:0]),
    .wdata (req_wdata),
    .rdata (sram_rdata)
  );

  always_comb begin
    rd_mux = BAD_DATA;
    if (req_is_out)        rd_mux = out_byte;
    else if (req_in_range) rd_mux = sram_rdata;
  end

  assign bus.mem_ready = resp;
  assign bus.mem_rdata = resp ? rd_mux : '0;
  assign out_byte_en   = resp && req_is_out && !req_is_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
      last_read  <= '0;
      last_valid <= 1'b0;
      out_byte   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        req_addr  <= bus.mem_addr & 32'hFFFF_FFFC;
        req_wdata <= bus.mem_wdata;
        req_wstrb <= bus.mem_wstrb;
      end
      if (resp) begin
        if (req_is_read) begin
          last_read  <= req_word;
          last_valid <= 1'b1;
        end else begin
          if (req_word[29:PW] == last_read[29:PW]) last_valid <= 1'b0;
          if (req_is_out) out_byte <= req_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_latency_responder.sv
// Randomized bench for mem_latency_responder against a transaction-level
// memory/latency model, preceded by directed scenarios.
module tb_mem_latency_responder;

  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned LAT    = 4;
  localparam int unsigned PLAT   = 1;
  localparam int unsigned PWORDS = 8;
  localparam logic [31:0] OUTA   = 32'h1000_0000;
  localparam logic [31:0] BADD   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] out_byte;
  logic        out_byte_en;

  mem_latency_responder_if bus();

  mem_latency_responder #(
    .DEPTH_WORDS  (DEPTH),
    .LATENCY      (LAT),
    .PAGE_LATENCY (PLAT),
    .PAGE_WORDS   (PWORDS),
    .OUT_ADDR     (OUTA),
    .BAD_DATA     (BADD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .out_byte    (out_byte),
    .out_byte_en (out_byte_en)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: word-level memory with per-byte knowledge, last read word
  logic [31:0]     mdl_mem   [int unsigned];
  logic [3:0]      mdl_known [int unsigned];
  longint unsigned mdl_last;
  bit              mdl_last_ok;
  logic [31:0]     mdl_out;
  logic [31:0]     prev_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned expected_wait(input logic [31:0] addr, input logic [3:0] wstrb);
    longint unsigned w = longint'(addr >> 2);
    if (wstrb == 4'b0000 && mdl_last_ok && w < DEPTH && w == mdl_last + 1
        && (w / PWORDS) == (mdl_last / PWORDS))
      return PLAT;
    return LAT;
  endfunction

  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int unsigned     exp_n = expected_wait(addr, wstrb);
    longint unsigned w = longint'(addr >> 2);
    bit              is_out = (addr >> 2) == (OUTA >> 2);
    bit              is_rd = (wstrb == 4'b0000);
    int              cycles = 0;
    bit              got = 0;
    logic [31:0]     rdata = '0;
    logic            en_seen = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (bus.mem_ready === 1'b1) begin
        got = 1;
        rdata = bus.mem_rdata;
        en_seen = out_byte_en;
      end else if (out_byte_en !== 1'b0) begin
        check("out_byte_en_early", {31'd0, out_byte_en}, 32'd0);
      end
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    check("ready_seen", {31'd0, got}, 32'd1);
    if (got) begin
      check("latency", 32'(cycles), 32'(exp_n + 1));
      check("out_byte_en", {31'd0, en_seen}, {31'd0, is_out && !is_rd});
      if (is_rd) begin
        if (is_out) check("rdata_mmio", rdata, mdl_out);
        else if (w >= DEPTH) check("rdata_unmapped", rdata, BADD);
        else if (mdl_known.exists(int'(w)) && mdl_known[int'(w)] == 4'hF)
          check("rdata", rdata, mdl_mem[int'(w)]);
      end
      // model update for the completed transfer
      if (is_rd) begin
        mdl_last = w;
        mdl_last_ok = 1;
      end else begin
        if (mdl_last_ok && (w / PWORDS) == (mdl_last / PWORDS)) mdl_last_ok = 0;
        if (is_out) mdl_out = wdata;
        else if (w < DEPTH) begin
          if (!mdl_mem.exists(int'(w))) begin
            mdl_mem[int'(w)] = '0;
            mdl_known[int'(w)] = '0;
          end
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
              mdl_mem[int'(w)][8*b +: 8] = wdata[8*b +: 8];
              mdl_known[int'(w)][b] = 1'b1;
            end
          end
        end
      end
    end
    @(negedge clk);
    check("ready_pulse", {31'd0, bus.mem_ready}, 32'd0);
    check("out_byte", out_byte, mdl_out);
    prev_addr = addr & 32'hFFFF_FFFC;
  endtask

  // Requester drops valid after k WAIT cycles; nothing must complete
  task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input int k);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("abort_no_ready", {31'd0, bus.mem_ready}, 32'd0);
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_ready_after", {31'd0, bus.mem_ready}, 32'd0);
    end
  endtask

  task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] wdata);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    @(negedge clk);
    check("rst_no_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("rst_out_byte", out_byte, 32'd0);
    reset = 1'b0;
    mdl_last_ok = 0;
    mdl_out = '0;
    @(negedge clk);
    check("rst_no_ready_after", {31'd0, bus.mem_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int unsigned r;
    mdl_last = 0;
    mdl_last_ok = 0;
    mdl_out = '0;
    prev_addr = '0;
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("reset_rdata", bus.mem_rdata, 32'd0);
    check("reset_out_byte", out_byte, 32'd0);
    check("reset_out_en", {31'd0, out_byte_en}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // basic write/read
    xfer(32'h40, 32'h1234_5678, 4'hF);
    xfer(32'h40, 32'h0, 4'h0);
    // open-page run, then new page
    for (int i = 0; i < 8; i++) xfer(32'h100 + 32'(4 * i), 32'h0, 4'h0);
    xfer(32'h120, 32'h0, 4'h0);
    // byte strobe merge
    xfer(32'h200, 32'hFFFF_FFFF, 4'hF);
    xfer(32'h200, 32'h0000_00AB, 4'b0001);
    xfer(32'h200, 32'h0, 4'h0);
    check("strobe_merge_model", mdl_mem[32'h80], 32'hFFFF_FFAB);
    // MMIO and unmapped
    xfer(OUTA, 32'h41, 4'hF);
    xfer(OUTA, 32'h0, 4'h0);
    xfer(32'h2000_0000, 32'h0, 4'h0);
    xfer(32'h2000_0000, 32'h5555_5555, 4'hF);
    // top of memory: next word is unmapped, not a wrap
    xfer(32'((DEPTH - 1) * 4), 32'hCAFE_0001, 4'hF);
    xfer(32'((DEPTH - 2) * 4), 32'h0, 4'h0);
    xfer(32'((DEPTH - 1) * 4), 32'h0, 4'h0);
    xfer(32'(DEPTH * 4), 32'h0, 4'h0);
    // aborted write leaves memory untouched
    xfer(32'h300, 32'h0BAD_F00D, 4'hF);
    abort_write(32'h300, 32'h7777_7777, 4'hF, 2);
    xfer(32'h300, 32'h0, 4'h0);
    // reset during WAIT clears the page tracker and drops the write
    xfer(32'h600, 32'hA5A5_A5A5, 4'hF);
    xfer(32'h500, 32'h0, 4'h0);
    reset_mid_write(32'h600, 32'h1111_1111);
    xfer(32'h504, 32'h0, 4'h0);
    xfer(32'h600, 32'h0, 4'h0);

    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: a = prev_addr + 32'd4;
        4, 5:       a = 32'h100 + 32'($urandom_range(0, 63) * 4);
        6:          a = OUTA;
        7:          a = 32'h2000_0000 + 32'($urandom_range(0, 255) * 4);
        8:          a = 32'(($urandom_range(0, 3) + DEPTH - 2) * 4);
        default:    a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      d = $urandom;
      s = ($urandom_range(0, 9) < 6) ? 4'h0 : 4'($urandom_range(1, 15));
      if (s == 4'h0) a = a | 32'($urandom_range(0, 3));
      if (s != 4'h0 && $urandom_range(0, 9) == 0)
        abort_write(a, d, s, int'($urandom_range(1, LAT)));
      else
        xfer(a, d, s);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
